rr_decoder_arbiter: RTL and testbench
=====================================

// Module: rr_decoder_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 8-way resource between 8 requesters.
//  Selects a winner index (3 bits) and drives it through an enabled 3-to-8 decoder to give a one-hot grant.
//  Sits in front of decoder-driven select lines (chip selects, bus enables), so that at most one line is active per cycle.
//  Enforces a maximum hold time so that one requester cannot starve the others.
// PARAMETERS
//  MAX_HOLD  16                      max consecutive cycles one grant may stay asserted (>=1)
//  CNT_W     $clog2(MAX_HOLD+1)      hold-counter width (derived; do not override)
// PORTS
//  clk        in   1    system clock, rising-edge
//  rst        in   1    asynchronous reset, active-high
//  en         in   1    arbitration enable; gates new grants only
//  req        in   8    request vector; req[k] held high while requester k wants or uses the resource
//  grant      out  8    one-hot grant (decoder output); all-zero when idle
//  grant_idx  out  3    binary index of current winner; valid only while busy=1
//  busy       out  1    high while a grant is asserted
//  timeout    out  1    one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, grant=0, grant_idx=0, busy=0, timeout=0, hold_cnt=0, last_ptr=7.
//   With last_ptr=7, requester 0 has top priority after reset.
//  FSM states: IDLE, BUSY, GAP.
//  IDLE: if en && |req, pick the first set req[k] scanning k = last_ptr+1, last_ptr+2, ... mod 8.
//   Register k into grant_idx, go to BUSY, hold_cnt=1.
//   Latency: grant appears on the clock edge after req is sampled (1 cycle).
//  BUSY: grant = decode(grant_idx), busy=1. Each cycle:
//   - req[grant_idx]==0: release, last_ptr<=grant_idx, go to GAP.
//   - else if hold_cnt==MAX_HOLD: forced release, timeout<=1 for one cycle, last_ptr<=grant_idx, go to GAP.
//   - else hold_cnt<=hold_cnt+1, stay in BUSY.
//   - Both true in the same cycle: treat as a normal release (no timeout pulse).
//  GAP: one dead cycle with grant=0 and busy=0, then IDLE.
//   Guarantees a turnaround cycle; two grants never appear back-to-back.
//   The request/grant cycle is a minimum of 3 clocks.
//  Grant stays asserted for exactly min(request duration, MAX_HOLD) cycles.
//   Requests from other requesters do not affect the current grant.
//  en=0: no new grant is issued from IDLE. A grant already in BUSY runs to release or timeout.
//  Wrap-around: the scan index is 3-bit modulo. Winner 7 makes requester 0 next-highest priority.
//  A requester that times out and keeps req high becomes lowest priority. It is re-granted only when no other req is set.
//  Single requester with req held permanently: pattern MAX_HOLD on, 1 gap, 1 idle, repeating.
//  Reset mid-grant: grant drops to 0 asynchronously. Priority returns to req0.
//  Invariant: $countones(grant) <= 1 at all times. grant != 0 iff busy.
//  All outputs are registered except grant, which is the decoder output from registered grant_idx and busy.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, GAP=2'd2), N_REQ=8, IDX_W=3.
//  Sub-module decoder_3to8_en:
//   ports (d[7:0] out, i[2:0] in, en in); en = busy.
//   Purely combinational; gives d = en ? 8'b1<<i : 0.
//  Top level holds the FSM, round-robin priority scan, hold counter and last_ptr register.
// TESTING
//  1 Reset with req=8'hFF, then release reset with en=1.
//    -> grant=8'h01 one cycle later; busy=1; grant_idx=0.
//  2 req=8'h24 constant, MAX_HOLD=16.
//    -> grant 8'h04 for 16 cycles with timeout pulse at end, 1 gap, 1 idle.
//    -> then 8'h20 for 16 cycles, then back to 8'h04.
//  3 req[3] high for 5 cycles only.
//    -> grant=8'h08 for exactly 5 cycles, no timeout, busy low in the 6th cycle (GAP).
//  4 After winner 7, req=8'h81.
//    -> next grant is 8'h01 (wrap-around); following grant is 8'h80.
//  5 en=0 during a grant to req1.
//    -> grant 8'h02 completes; no new grant while en=0 even with req=8'hFF.
//  6 Assert rst mid-grant (grant=8'h10).
//    -> grant=0 immediately, before the next edge.
//    -> after release with req=8'h11, first grant is 8'h01.
//  All tests: assert onehot0(grant) and grant==(busy ? 1<<grant_idx : 0) every cycle.

Source files
------------

// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
// Holds the FSM encoding, requester geometry and the rotating priority scan.
package rr_decoder_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    // First set request after last_ptr, wrapping modulo N_REQ; last_ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] last_ptr
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = last_ptr;
        found   = 1'b0;
        for (int unsigned o = 1; o <= N_REQ; o++) begin
            idx = last_ptr + IDX_W'(o);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_3to8_en.sv
// Enabled 3-to-8 one-hot decoder; all outputs low while disabled.
module decoder_3to8_en
    import rr_decoder_arbiter_pkg::*;
(
    output logic [N_REQ-1:0] d,
    input  logic [IDX_W-1:0] i,
    input  logic             en
);

    always_comb begin
        d = '0;
        if (en) begin
            d[i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for one shared resource with a bounded hold time and a
// mandatory dead cycle between grants; the one-hot grant comes from a decoder.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_ptr_q,  last_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic               busy_q,      busy_d;
    logic               timeout_q,   timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_ptr_q  <= IDX_W'(N_REQ - 1);
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_ptr_q  <= last_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    // A dropped request wins over the hold limit, so a simultaneous release never pulses timeout.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_ptr_d  = last_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    grant_idx_d = rr_pick(req, last_ptr_q);
                    hold_cnt_d  = CNT_W'(1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (!req[grant_idx_q]) begin
                    last_ptr_d = grant_idx_q;
                    hold_cnt_d = '0;
                    state_d    = GAP;
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    last_ptr_d = grant_idx_q;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = GAP;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    decoder_3to8_en u_dec (
        .d  (grant),
        .i  (grant_idx_q),
        .en (busy_q)
    );

    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: fixed vector table, directed corner sequences and
// a randomized run against a request-level reference model.
module tb_rr_decoder_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model: who owns the resource, for how long, and who was served last.
    int m_owner;
    int m_held;
    int m_last;
    bit m_gap;
    bit m_to;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner] || m_held == MAX_HOLD) begin
                m_to    = req[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (en && req != 8'h00) begin
            for (int o = 1; o <= 8; o++) begin
                int k;
                k = (m_last + o) % 8;
                if (m_owner < 0 && req[k]) m_owner = k;
            end
            m_held = 1;
        end
    endtask

    task automatic model_check();
        logic [7:0] exp_g;
        exp_g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("model_grant", 32'(grant), 32'(exp_g));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk("model_grant_idx", 32'(grant_idx), 32'(m_owner));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant_idx", 32'(grant_idx), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Structural invariants sampled away from the active edge.
    always @(negedge clk) begin
        chk("inv_onehot0", 32'($countones(grant) <= 1), 32'h1);
        chk("inv_grant_vs_idx", 32'(grant), 32'(busy ? (8'h01 << grant_idx) : 8'h00));
    end

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] exp_grant;
        logic       exp_busy;
        logic       exp_timeout;
    } vec_t;

    vec_t vecs[16];
    logic [7:0] req_r;

    initial begin
        vecs[0]  = '{1'b1, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h81, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h81, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h81, 8'h01, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'hFF, 8'h80, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h7F, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'hFF, 8'h01, 1'b1, 1'b0};

        #1;
        // Reset with all requests up, then wrap-around and enable gating table.
        en  = 1'b1;
        req = 8'hFF;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_timeout));
        end

        // Two persistent requesters alternate, each cut off by the hold limit.
        req = 8'h00;
        do_reset();
        en  = 1'b1;
        req = 8'h24;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("hold_a_grant", 32'(grant), 32'h04);
            chk("hold_a_no_timeout", 32'(timeout), 32'h0);
        end
        tick();
        chk("hold_a_gap_grant", 32'(grant), 32'h00);
        chk("hold_a_timeout", 32'(timeout), 32'h1);
        tick();
        chk("hold_a_idle_grant", 32'(grant), 32'h00);
        chk("hold_a_idle_timeout", 32'(timeout), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("hold_b_grant", 32'(grant), 32'h20);
        end
        tick();
        chk("hold_b_timeout", 32'(timeout), 32'h1);
        tick();
        tick();
        chk("hold_back_to_a", 32'(grant), 32'h04);

        // Short request: grant lasts exactly as long as the request.
        req = 8'h00;
        do_reset();
        en  = 1'b1;
        req = 8'h08;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("short_grant", 32'(grant), 32'h08);
        end
        req = 8'h00;
        tick();
        chk("short_gap_busy", 32'(busy), 32'h0);
        chk("short_no_timeout", 32'(timeout), 32'h0);

        // en dropped mid-grant: grant finishes, nothing new until en returns.
        do_reset();
        en  = 1'b1;
        req = 8'h02;
        tick();
        chk("en_first_grant", 32'(grant), 32'h02);
        en  = 1'b0;
        req = 8'hFF;
        repeat (3) begin
            tick();
            chk("en_hold_grant", 32'(grant), 32'h02);
        end
        req = 8'hFD;
        tick();
        chk("en_release", 32'(grant), 32'h00);
        req = 8'hFF;
        repeat (4) begin
            tick();
            chk("en_blocked", 32'(busy), 32'h0);
        end
        en = 1'b1;
        tick();
        chk("en_resume_grant", 32'(grant), 32'h04);

        // Asynchronous reset in the middle of a grant.
        req = 8'h00;
        do_reset();
        en  = 1'b1;
        req = 8'h10;
        tick();
        tick();
        chk("mid_rst_pre", 32'(grant), 32'h10);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 8'h11;
        tick();
        chk("mid_rst_priority", 32'(grant), 32'h01);

        // Randomized run: requests persist for random stretches so holds and timeouts occur.
        req = 8'h00;
        do_reset();
        req_r = 8'h00;
        en    = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 19) == 0) req_r[k] = ~req_r[k];
            end
            if ($urandom_range(0, 39) == 0) en = ~en;
            req = req_r;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
